sudoku_puzzle_loader: RTL

Fetches one puzzle from the synchronous puzzle ROM and assembles it into the packed `init_board` / `init_board_blank` vectors. It then pulses `start` so the game block latches the puzzle. It tracks the game's `valid` (solved) pulse to advance to the next puzzle, with wrap-around. It sits between the puzzle ROM and the game block, acting as the producer side of the game's start/init_board interface.

---
 rtl/sudoku_pkg.sv | 21 ++
 rtl/sudoku_puzzle_loader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/sudoku_pkg.sv
// Shared board geometry, loader state encoding and cell indexing helper
// for the sudoku game blocks.
package sudoku_pkg;

  localparam int CELLS   = 81;
  localparam int DIGIT_W = 4;
  localparam int BOARD_W = CELLS * DIGIT_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_START = 3'd3,
    ST_PLAY  = 3'd4
  } loader_state_t;

  function automatic logic [6:0] cell_index(input logic [3:0] row, input logic [3:0] col);
    return 7'(int'(row) * 9 + int'(col));
  endfunction

endpackage

// File: rtl/sudoku_puzzle_loader.sv
// Streams one 81-cell puzzle out of the synchronous puzzle ROM into the packed
// init_board/init_board_blank vectors, then pulses start for the game block.
module sudoku_puzzle_loader
  import sudoku_pkg::*;
#(
  parameter int NUM_PUZZLES = 8,
  parameter int ADDR_W      = 10,
  localparam int IDX_W      = (NUM_PUZZLES > 1) ? $clog2(NUM_PUZZLES) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic                next,
  input  logic                solved,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [3:0]          rom_data,
  output logic [BOARD_W-1:0]  init_board,
  output logic [CELLS-1:0]    init_board_blank,
  output logic                start,
  output logic                busy,
  output logic [IDX_W-1:0]    puzzle_idx,
  output logic [2:0]          dbg_state
);

  // Producer handshake: start is a one-cycle strobe with no back-pressure;
  // init_board/init_board_blank are valid and stable for that whole cycle.

  loader_state_t      state_q, state_d;
  logic [6:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
  logic               cap_valid_q, cap_valid_d;
  logic [6:0]         cap_cell_q, cap_cell_d;
  logic               clear_blank;
  logic [BOARD_W-1:0] board_q;
  logic [CELLS-1:0]   blank_q;
  logic               digit_ok;

  assign idx_inc  = (idx_q == IDX_W'(NUM_PUZZLES - 1)) ? '0 : idx_q + 1'b1;
  assign digit_ok = (rom_data != 4'd0) && (rom_data <= 4'd9);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      cap_valid_q <= 1'b0;
      cap_cell_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      cap_valid_q <= cap_valid_d;
      cap_cell_q  <= cap_cell_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    cap_valid_d = 1'b0;
    cap_cell_d  = cnt_q;
    clear_blank = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // An advance requested together with load is applied before the fetch.
        if (next) idx_d = idx_inc;
        if (load) begin
          state_d     = ST_FETCH;
          cnt_d       = '0;
          clear_blank = 1'b1;
        end
      end
      ST_FETCH: begin
        cap_valid_d = 1'b1;
        cap_cell_d  = cnt_q;
        if (cnt_q == 7'd80) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_DRAIN: state_d = ST_START;
      ST_START: state_d = ST_PLAY;
      ST_PLAY: begin
        if (solved || next) idx_d = idx_inc;
        if (load) begin
          state_d     = ST_FETCH;
          cnt_d       = '0;
          clear_blank = 1'b1;
        end else if (solved) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Data for the address issued last cycle lands in that cell's slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      board_q <= '0;
      blank_q <= '0;
    end else if (clear_blank) begin
      blank_q <= '0;
    end else begin
      for (int i = 0; i < CELLS; i++) begin
        if (cap_valid_q && (cap_cell_q == 7'(i))) begin
          board_q[i*DIGIT_W +: DIGIT_W] <= digit_ok ? rom_data : 4'd0;
          blank_q[i]                    <= !digit_ok;
        end
      end
    end
  end

  assign rom_addr         = (state_q == ST_FETCH) ?
                            ADDR_W'(int'(idx_q) * CELLS + int'(cnt_q)) : '0;
  assign init_board       = board_q;
  assign init_board_blank = blank_q;
  assign start            = (state_q == ST_START);
  assign busy             = (state_q == ST_FETCH) || (state_q == ST_DRAIN) ||
                            (state_q == ST_START);
  assign puzzle_idx       = idx_q;
  assign dbg_state        = state_q;

endmodule
